serial_word_rx: RTL and testbench
=================================

# serial_word_rx

- Deserialising receiver for the serial bit stream produced by the universal shift register in its PISO/SISO modes.
- Strips start/stop framing and optionally checks parity.
- Assembles DW-bit words and presents them downstream through a one-entry valid/ready output buffer.
- Reports framing, parity and overrun errors as single-cycle pulses.

## Interface
- DW, 4, data bits per frame (DW ≥ 2)
- LSB_FIRST, 1, 1: first data bit received lands in bit 0; 0: lands in bit DW-1
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- sin  input  1  serial line; idle level 1
- bit_en  input  1  bit strobe: sin is sampled only on clock edges where bit_en=1
- dout_ready  input  1  downstream accepts dout when high with dout_valid
- dout  output  DW  received word
- dout_valid  output  1  dout holds an unconsumed word
- busy  output  1  FSM not in IDLE
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- par_err  output  1  one-cycle pulse: parity mismatch (only with PARITY_CHECK_EN)
- overrun  output  1  one-cycle pulse: completed word dropped because buffer full

## Operation
- Reset (async assert, sync release): state=IDLE, shift reg=0, bit counter=0, dout=0, dout_valid=0, busy=0, all error pulses 0.
- Frame format: start bit 0, DW data bits, [parity bit], stop bit 1.
- FSM, advancing only on bit_en=1:
  - IDLE: sin=0 → DATA, counter cleared; sin=1 → stay.
  - DATA: shift sin in per LSB_FIRST; counter increments; after DW-th bit → PARITY (macro defined) or STOP.
  - PARITY: capture parity bit → STOP.
  - STOP: sin=1 → word complete, → IDLE. sin=0 → frame_err, word discarded, → BREAK.
  - BREAK: wait for sin=1 sample → IDLE. No start bit is detected while line held low.
- Word complete with parity error: par_err pulses, word discarded, no frame_err.
- Output buffer:
  - Word completes with dout_valid=0, or with dout_valid=1 and dout_ready=1 on the same edge: dout loaded, dout_valid=1, no overrun.
  - Word completes with dout_valid=1 and dout_ready=0: new word dropped, dout unchanged, overrun pulses.
  - dout_valid=1 and dout_ready=1 with no completion: dout_valid→0, dout retains its value.
- frame_err has priority over par_err; at most one error pulse per frame.
- bit_en=0 freezes FSM and shift register; the handshake still operates every clock.
- Reset mid-frame aborts the frame and clears the buffer; no error is reported.

## Timing
- A bit sampled at edge N is reflected in internal state after edge N.
- Stop bit sampled at edge N: dout/dout_valid, or an error pulse, are visible after edge N. Each pulse is high for exactly the one following cycle.
- Minimum bit_en spacing is 1 clock; back-to-back frames are legal: a start bit may be sampled on the strobe right after the stop bit.
- busy is high from the edge after the start bit is sampled until the edge on which the stop bit is sampled.
- Word latency from start-bit strobe: DW+2 strobes (DW+3 with parity).

## Configuration
- PARITY_CHECK_EN defined: frame includes one even-parity bit after data (XOR of data bits and parity = 0); mismatch → par_err, word discarded.
- Undefined: no parity bit in the frame; PARITY state removed; par_err tied to 0.

## Test plan
- DW=4, LSB_FIRST=1, no parity, bit_en every cycle, sin = 0,1,0,1,1,1 → dout=4'b1101 (0xD), dout_valid=1 one edge after the stop sample, busy low again.
- Same frame with LSB_FIRST=0 → dout=4'b1011 (0xB); bit_en with 3 idle clocks between strobes gives identical result.
- Stop bit sent as 0, then sin held 0 for 5 strobes, then 1, then frame for 0x3 → frame_err single pulse, no false start during the low period, then dout=0x3.
- Two frames 0xA then 0x5 with dout_ready=0 → dout stays 0xA, overrun pulses once. Repeat with dout_ready=1 on the completion edge → dout=0x5, no overrun.
- PARITY_CHECK_EN, data 0x7 with parity bit 1 → dout=0x7. Same data with parity bit 0 → par_err pulse, dout_valid stays 0.
- Assert rst after 2 data bits, release, send 0x9 → dout=0x9. No error pulses; all outputs 0 during reset.

Source files
------------

// File: rtl/serial_word_rx.sv
// Start/stop framed serial-to-parallel receiver with a one-entry valid/ready output buffer.
// Define PARITY_CHECK_EN to expect and check an even-parity bit after the data bits.
module serial_word_rx #(
    parameter int unsigned DW        = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          sin_i,
    input  logic          bit_en_i,
    input  logic          dout_ready_i,
    output logic [DW-1:0] dout_o,
    output logic          dout_valid_o,
    output logic          busy_o,
    output logic          frame_err_o,
    output logic          par_err_o,
    output logic          overrun_o
);

    localparam int unsigned CntW = $clog2(DW);

    typedef enum logic [2:0] {
        StIdle,
        StData,
`ifdef PARITY_CHECK_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_e;

    state_e          state_q;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [CntW-1:0] cnt_q;
    logic [DW-1:0]   dout_q;
    logic            valid_q, busy_q, ferr_q, ovr_q;
    logic            par_bad;
    logic            word_done;

`ifdef PARITY_CHECK_EN
    logic par_bad_q, perr_q;
    assign par_bad   = par_bad_q;
    assign par_err_o = perr_q;
`else
    assign par_bad   = 1'b0;
    assign par_err_o = 1'b0;
`endif

    always_comb begin
        shreg_d = shreg_q;
        if (LSB_FIRST) begin
            shreg_d = {sin_i, shreg_q[DW-1:1]};
        end else begin
            shreg_d = {shreg_q[DW-2:0], sin_i};
        end
        word_done = bit_en_i && (state_q == StStop) && sin_i && !par_bad;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q <= 1'b0;
`endif
            if (bit_en_i) begin
                unique case (state_q)
                    StIdle: begin
                        if (!sin_i) begin
                            state_q <= StData;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    StData: begin
                        shreg_q <= shreg_d;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == CntW'(DW - 1)) begin
`ifdef PARITY_CHECK_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
`ifdef PARITY_CHECK_EN
                    StParity: begin
                        par_bad_q <= (^shreg_q) ^ sin_i;
                        state_q   <= StStop;
                    end
`endif
                    StStop: begin
                        if (sin_i) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
                            perr_q  <= par_bad_q;
`endif
                        end else begin
                            // Line still low: wait for it to return high before hunting a start bit
                            ferr_q  <= 1'b1;
                            state_q <= StBreak;
                        end
                    end
                    StBreak: begin
                        if (sin_i) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end

            if (word_done) begin
                if (!valid_q || dout_ready_i) begin
                    dout_q  <= shreg_q;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && dout_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: LSB-first and MSB-first instances share one serial line and are
// compared every cycle against a frame-level model; directed frames pin the model with literals.
module tb_serial_word_rx;

    localparam int DW = 4;
`ifdef PARITY_CHECK_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = DW + PAR + 1;  // samples after the start bit

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sin = 1'b1, bit_en = 1'b0, rdy = 1'b0;
    logic [DW-1:0] dout_l, dout_m;
    logic valid_l, busy_l, ferr_l, perr_l, ovr_l;
    logic valid_m, busy_m, ferr_m, perr_m, ovr_m;

    always #5 clk = ~clk;

    serial_word_rx #(.DW(DW), .LSB_FIRST(1'b1)) dut_l (
        .clk_i(clk), .rst_ni(rst_n), .sin_i(sin), .bit_en_i(bit_en), .dout_ready_i(rdy),
        .dout_o(dout_l), .dout_valid_o(valid_l), .busy_o(busy_l), .frame_err_o(ferr_l),
        .par_err_o(perr_l), .overrun_o(ovr_l)
    );

    serial_word_rx #(.DW(DW), .LSB_FIRST(1'b0)) dut_m (
        .clk_i(clk), .rst_ni(rst_n), .sin_i(sin), .bit_en_i(bit_en), .dout_ready_i(rdy),
        .dout_o(dout_m), .dout_valid_o(valid_m), .busy_o(busy_m), .frame_err_o(ferr_m),
        .par_err_o(perr_m), .overrun_o(ovr_m)
    );

    int errors = 0;
    int checks = 0;

    // Frame-level reference model
    bit          m_inf, m_brk, m_valid, m_ferr, m_perr, m_ovr;
    int          m_n;
    bit          m_bits[0:15];
    logic [DW-1:0] m_dl, m_dm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_inf = 0; m_brk = 0; m_valid = 0; m_ferr = 0; m_perr = 0; m_ovr = 0;
        m_n = 0; m_dl = '0; m_dm = '0;
    endtask

    task automatic model_step(input bit s, input bit e, input bit r);
        bit done;
        int ones;
        done = 0; m_ferr = 0; m_perr = 0; m_ovr = 0;
        if (e) begin
            if (m_brk) begin
                if (s) m_brk = 0;
            end else if (!m_inf) begin
                if (!s) begin m_inf = 1; m_n = 0; end
            end else begin
                m_bits[m_n] = s;
                m_n++;
                if (m_n == FL) begin
                    m_inf = 0;
                    ones = 0;
                    for (int i = 0; i < DW + PAR; i++) ones += int'(m_bits[i]);
                    if (!s) begin
                        m_ferr = 1; m_brk = 1;
                    end else if (PAR == 1 && (ones % 2) != 0) begin
                        m_perr = 1;
                    end else begin
                        done = 1;
                    end
                end
            end
        end
        if (done) begin
            if (!m_valid || r) begin
                for (int i = 0; i < DW; i++) begin
                    m_dl[i] = m_bits[i];
                    m_dm[DW-1-i] = m_bits[i];
                end
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && r) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        chk("dout_lsb", 32'(dout_l), 32'(m_dl));
        chk("dout_msb", 32'(dout_m), 32'(m_dm));
        chk("valid_lsb", 32'(valid_l), 32'(m_valid));
        chk("valid_msb", 32'(valid_m), 32'(m_valid));
        chk("busy", 32'({busy_l, busy_m}), 32'({2{m_inf | m_brk}}));
        chk("frame_err", 32'({ferr_l, ferr_m}), 32'({2{m_ferr}}));
        chk("par_err", 32'({perr_l, perr_m}), 32'({2{m_perr}}));
        chk("overrun", 32'({ovr_l, ovr_m}), 32'({2{m_ovr}}));
    endtask

    task automatic tick(input bit s, input bit e, input bit r);
        sin = s; bit_en = e; rdy = r;
        model_step(s, e, r);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit stop, input bit pgood,
                              input int gap, input bit r_mid, input bit r_last);
        logic fb[0:15];
        int   last;
        last = FL;
        fb[0] = 1'b0;
        for (int i = 0; i < DW; i++) fb[1+i] = d[i];
        if (PAR == 1) fb[DW+1] = (^d) ^ !pgood;
        fb[last] = stop;
        for (int k = 0; k <= last; k++) begin
            for (int g = 0; g < gap; g++) tick(fb[k], 1'b0, r_mid);
            tick(fb[k], 1'b1, (k == last) ? r_last : r_mid);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        sin = 1'b1; bit_en = 1'b0; rdy = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);

        // sin = 0,1,0,1,1,1
        send_frame(4'b1101, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        chk("lit_lsb_D", 32'(dout_l), 32'hD);
        chk("lit_msb_B", 32'(dout_m), 32'hB);
        chk("lit_valid", 32'(valid_l), 32'h1);
        chk("lit_busy_low", 32'(busy_l), 32'h0);
        tick(1'b1, 1'b1, 1'b1);

        send_frame(4'b1101, 1'b1, 1'b1, 3, 1'b0, 1'b0);
        chk("lit_gap_lsb_D", 32'(dout_l), 32'hD);
        chk("lit_gap_msb_B", 32'(dout_m), 32'hB);
        tick(1'b1, 1'b1, 1'b1);

        // Bad stop, line held low, then recovery
        send_frame(4'h6, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        chk("lit_frame_err", 32'(ferr_l), 32'h1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
        chk("lit_break_busy", 32'(busy_l), 32'h1);
        chk("lit_break_novalid", 32'(valid_l), 32'h0);
        tick(1'b1, 1'b1, 1'b0);
        send_frame(4'h3, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        chk("lit_after_break_3", 32'(dout_l), 32'h3);
        tick(1'b1, 1'b1, 1'b1);

        // Overrun, then replacement on the completion edge
        send_frame(4'hA, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_frame(4'h5, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        chk("lit_ovr_keep_A", 32'(dout_l), 32'hA);
        chk("lit_overrun", 32'(ovr_l), 32'h1);
        send_frame(4'h5, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        chk("lit_replace_5", 32'(dout_l), 32'h5);
        chk("lit_no_overrun", 32'(ovr_l), 32'h0);
        tick(1'b1, 1'b1, 1'b1);

`ifdef PARITY_CHECK_EN
        send_frame(4'h7, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        chk("lit_par_ok_7", 32'(dout_l), 32'h7);
        tick(1'b1, 1'b1, 1'b1);
        send_frame(4'h7, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        chk("lit_par_err", 32'(perr_l), 32'h1);
        chk("lit_par_novalid", 32'(valid_l), 32'h0);
`endif

        // Reset in the middle of a frame
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        do_reset();
        chk("lit_rst_dout", 32'(dout_l), 32'h0);
        chk("lit_rst_busy", 32'(busy_l), 32'h0);
        tick(1'b1, 1'b1, 1'b0);
        send_frame(4'h9, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        chk("lit_post_rst_9", 32'(dout_l), 32'h9);
        chk("lit_post_rst_noerr", 32'({ferr_l, perr_l, ovr_l}), 32'h0);

        // Randomised traffic
        for (int f = 0; f < 200; f++) begin
            int idle;
            idle = int'($urandom_range(0, 2));
            for (int i = 0; i < idle; i++) tick(1'b1, 1'($urandom), 1'($urandom));
            send_frame(DW'($urandom), ($urandom % 8) != 0, ($urandom % 6) != 0,
                       int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
